// File: rtl/scic_pkg.sv
// ---------------------------------------------------------------------------
// scic_pkg
// Shared definitions for the switch reader block.
//
// Contents:
//   SW_WIDTH_DEFAULT        default number of switch inputs
//   DEBOUNCE_CYCLES_DEFAULT default debounce hold time in clock cycles
//   COUNT_WIDTH             width of the per-bit debounce counter; holds
//                           up to 255, the largest legal DEBOUNCE_CYCLES
//   read_state_t            CPU read handshake states {IDLE, ACK, WAIT}
// ---------------------------------------------------------------------------
package scic_pkg;

    localparam int SW_WIDTH_DEFAULT        = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int COUNT_WIDTH             = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } read_state_t;

endpackage

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
// Single-bit switch conditioner: 2-flop synchronizer, debounce counter and
// debounced (stable) level.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a new synchronized level must persist (1..255)
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high reset
//   raw     in   asynchronous switch level
//   stable  out  debounced level
//   change  out  combinational pulse, high during the cycle whose rising
//                edge loads a new value into stable
// ---------------------------------------------------------------------------
module switch_debounce
    import scic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic change
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                   sync_meta;
    logic                   sync_level;
    logic [COUNT_WIDTH-1:0] count;

    // The change pulse is combinational so the top can set its sticky flag
    // on the same edge that stable takes the new level.
    assign change = (sync_level != stable) && (count == LAST_COUNT);

    // The counter only runs while the synchronized level disagrees with
    // stable, and is cleared on acceptance, so it never passes LAST_COUNT.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
            stable     <= 1'b0;
            count      <= '0;
        end else begin
            sync_meta  <= raw;
            sync_level <= sync_meta;
            if (sync_level == stable) begin
                count <= '0;
            end else if (change) begin
                stable <= sync_level;
                count  <= '0;
            end else begin
                count <= count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/switch_reader.sv
// ---------------------------------------------------------------------------
// switch_reader
// Debounced switch bank with sticky per-bit change flags and a simple
// CPU read handshake (IDLE -> ACK -> WAIT).  A read captures
// {changed, stable} and clears the change flags it reported.
//
// Optional feature: define SWITCH_READER_IRQ_EN to get a registered irq
// equal to OR(changed), one cycle behind changed.  Without the macro irq
// is tied to 0.
//
// Parameters:
//   SW_WIDTH         number of switch inputs
//   DEBOUNCE_CYCLES  debounce hold time in cycles (1..255)
//
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-high reset
//   switches  in   raw switch levels [SW_WIDTH]
//   rd_req    in   CPU read request (level)
//   rd_ack    out  one-cycle read acknowledge
//   rd_data   out  {changed, stable} captured at the read, held until the next
//   irq       out  change interrupt (see macro above)
// ---------------------------------------------------------------------------
module switch_reader
    import scic_pkg::*;
#(
    parameter int SW_WIDTH        = SW_WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic [2*SW_WIDTH-1:0] rd_data,
    output logic                  irq
);

    logic [SW_WIDTH-1:0] stable;
    logic [SW_WIDTH-1:0] change_pulse;
    logic [SW_WIDTH-1:0] changed;
    read_state_t         state;
    read_state_t         state_next;
    logic                capture;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock (clock),
            .reset (reset),
            .raw   (switches[i]),
            .stable(stable[i]),
            .change(change_pulse[i])
        );
    end

    // Read FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next state and outputs. WAIT blocks further acks until the
    // CPU drops rd_req.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        rd_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                rd_ack     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (!rd_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sticky change flags and read data. A new change arriving on the
    // capture edge is ORed in after the clear, so it survives for the
    // next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            changed <= '0;
            rd_data <= '0;
        end else begin
            if (capture) begin
                rd_data <= {changed, stable};
            end
            changed <= (capture ? '0 : changed) | change_pulse;
        end
    end

`ifdef SWITCH_READER_IRQ_EN
    logic irq_reg;

    // Interrupt follows OR(changed) one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |changed;
        end
    end

    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

endmodule
